// File: rtl/systolic_sched.sv
// Job sequencer for a square MAC array: takes K operand vector pairs, skews them onto
// the west/north edges, pads the wavefront with zero beats, then settles, flushes and signals done.
module systolic_sched #(
    parameter int width_p  = 32,
    parameter int dim_p    = 4,
    parameter int k_max_p  = 64,
    parameter int settle_p = 32,
    localparam int kw      = $clog2(k_max_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       halt_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [kw-1:0]              cmd_k_i,
    input  logic                       a_vec_valid_i,
    output logic                       a_vec_ready_o,
    input  logic [dim_p*width_p-1:0]   a_vec_i,
    input  logic                       b_vec_valid_i,
    output logic                       b_vec_ready_o,
    input  logic [dim_p*width_p-1:0]   b_vec_i,
    input  logic [dim_p-1:0]           edge_a_ready_i,
    input  logic [dim_p-1:0]           edge_b_ready_i,
    output logic [dim_p-1:0]           edge_a_valid_o,
    output logic [dim_p-1:0]           edge_b_valid_o,
    output logic [dim_p*width_p-1:0]   edge_a_o,
    output logic [dim_p*width_p-1:0]   edge_b_o,
    output logic                       en_o,
    output logic                       flush_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int cnt_max_lp = (k_max_p + dim_p > settle_p) ? (k_max_p + dim_p) : settle_p;
    localparam int cw         = $clog2(cnt_max_lp + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_SETTLE,
        ST_FLUSH,
        ST_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [kw-1:0]              k_q, k_d;
    logic [cw-1:0]              cnt_q, cnt_d;
    logic [kw-1:0]              k_clamped;
    logic                       edge_ok;
    logic                       beat;
    logic                       feed_beat;
    logic [dim_p*width_p-1:0]   a_src;
    logic [dim_p*width_p-1:0]   b_src;

    assign k_clamped = (cmd_k_i > kw'(k_max_p)) ? kw'(k_max_p) : cmd_k_i;
    assign edge_ok   = (&edge_a_ready_i) & (&edge_b_ready_i) & ~halt_i;

    always_comb begin
        beat = 1'b0;
        case (state_q)
            ST_FEED:  beat = edge_ok & a_vec_valid_i & b_vec_valid_i;
            ST_DRAIN: beat = edge_ok;
            default:  beat = 1'b0;
        endcase
    end

    assign feed_beat = beat & (state_q == ST_FEED);

    // Outside FEED the edge sources are zero, which is what pads the wavefront in DRAIN.
    assign a_src = (state_q == ST_FEED) ? a_vec_i : '0;
    assign b_src = (state_q == ST_FEED) ? b_vec_i : '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    k_d   = k_clamped;
                    cnt_d = '0;
                    if (k_clamped != '0)
                        state_d = ST_FEED;
                    else if (dim_p == 1)
                        state_d = ST_SETTLE;
                    else
                        state_d = ST_DRAIN;
                end
            end
            ST_FEED: begin
                if (beat) begin
                    if (cnt_q + cw'(1) == cw'(k_q)) begin
                        cnt_d   = '0;
                        state_d = (dim_p == 1) ? ST_SETTLE : ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + cw'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (beat) begin
                    if (cnt_q + cw'(1) == cw'(dim_p - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        cnt_d = cnt_q + cw'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (!halt_i) begin
                    if (cnt_q + cw'(1) == cw'(settle_p)) begin
                        cnt_d   = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_q + cw'(1);
                    end
                end
            end
            ST_FLUSH: if (!halt_i) state_d = ST_DONE;
            ST_DONE:  if (!halt_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are gated by halt so a halted FLUSH/DONE cycle is held, not lost.
    assign cmd_ready_o    = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign flush_o        = (state_q == ST_FLUSH) & ~halt_i;
    assign done_o         = (state_q == ST_DONE) & ~halt_i;
    assign en_o           = ~halt_i;
    assign a_vec_ready_o  = feed_beat;
    assign b_vec_ready_o  = feed_beat;
    assign edge_a_valid_o = {dim_p{beat}};
    assign edge_b_valid_o = {dim_p{beat}};

    assign edge_a_o[0 +: width_p] = a_src[0 +: width_p];
    assign edge_b_o[0 +: width_p] = b_src[0 +: width_p];

    // Lane gi passes through a gi-deep chain that only advances on a beat.
    genvar gi;
    generate
        for (gi = 1; gi < dim_p; gi++) begin : g_skew
            logic [width_p-1:0] a_chain_q [gi];
            logic [width_p-1:0] a_chain_d [gi];
            logic [width_p-1:0] b_chain_q [gi];
            logic [width_p-1:0] b_chain_d [gi];

            always_comb begin
                a_chain_d = a_chain_q;
                b_chain_d = b_chain_q;
                if (beat) begin
                    a_chain_d[0] = a_src[gi*width_p +: width_p];
                    b_chain_d[0] = b_src[gi*width_p +: width_p];
                    for (int j = 1; j < gi; j++) begin
                        a_chain_d[j] = a_chain_q[j-1];
                        b_chain_d[j] = b_chain_q[j-1];
                    end
                end
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int j = 0; j < gi; j++) begin
                        a_chain_q[j] <= '0;
                        b_chain_q[j] <= '0;
                    end
                end else begin
                    a_chain_q <= a_chain_d;
                    b_chain_q <= b_chain_d;
                end
            end

            assign edge_a_o[gi*width_p +: width_p] = a_chain_q[gi-1];
            assign edge_b_o[gi*width_p +: width_p] = b_chain_q[gi-1];
        end
    endgenerate

endmodule

// File: tb/tb_systolic_sched.sv
// Randomized bench for systolic_sched: a beat/phase-level job model predicts every
// cycle's handshakes, skewed edge data and flush/done timing.
module tb_systolic_sched;

    localparam int W    = 16;
    localparam int DIM  = 2;
    localparam int KMAX = 6;
    localparam int SET  = 8;
    localparam int KW   = $clog2(KMAX + 1);

    logic                 clk = 1'b0;
    logic                 reset_n_i;
    logic                 halt_i;
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [KW-1:0]        cmd_k_i;
    logic                 a_vec_valid_i, a_vec_ready_o;
    logic [DIM*W-1:0]     a_vec_i;
    logic                 b_vec_valid_i, b_vec_ready_o;
    logic [DIM*W-1:0]     b_vec_i;
    logic [DIM-1:0]       edge_a_ready_i, edge_b_ready_i;
    logic [DIM-1:0]       edge_a_valid_o, edge_b_valid_o;
    logic [DIM*W-1:0]     edge_a_o, edge_b_o;
    logic                 en_o, flush_o, busy_o, done_o;

    int n_checks = 0;
    int n_errors = 0;
    bit hold_cmd = 1'b0;

    logic [W-1:0] a_mat [KMAX][DIM];
    logic [W-1:0] b_mat [KMAX][DIM];

    always #5 clk = ~clk;

    systolic_sched #(
        .width_p(W), .dim_p(DIM), .k_max_p(KMAX), .settle_p(SET)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .halt_i(halt_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_k_i(cmd_k_i),
        .a_vec_valid_i(a_vec_valid_i), .a_vec_ready_o(a_vec_ready_o), .a_vec_i(a_vec_i),
        .b_vec_valid_i(b_vec_valid_i), .b_vec_ready_o(b_vec_ready_o), .b_vec_i(b_vec_i),
        .edge_a_ready_i(edge_a_ready_i), .edge_b_ready_i(edge_b_ready_i),
        .edge_a_valid_o(edge_a_valid_o), .edge_b_valid_o(edge_b_valid_o),
        .edge_a_o(edge_a_o), .edge_b_o(edge_b_o),
        .en_o(en_o), .flush_o(flush_o), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DIM*W-1:0] pack_vec(input bit is_b, input int idx);
        logic [DIM*W-1:0] r;
        for (int i = 0; i < DIM; i++)
            r[i*W +: W] = is_b ? b_mat[idx][i] : a_mat[idx][i];
        return r;
    endfunction

    // Edge beat n carries operand vector (n-i) on lane i, zero outside 0..K-1.
    function automatic logic [DIM*W-1:0] exp_edge(input bit is_b, input int n, input int k);
        logic [DIM*W-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            idx = n - i;
            if (idx >= 0 && idx < k)
                r[i*W +: W] = is_b ? b_mat[idx][i] : a_mat[idx][i];
        end
        return r;
    endfunction

    task automatic run_job(input int k_cmd, input bit fill, input bit rnd,
                           input bit stall_b1, input bit halt_flush);
        int  k, nb, n, phase, settle_left, cyc, hcnt;
        bit  fin, ok, exp_beat;
        k  = (k_cmd > KMAX) ? KMAX : k_cmd;
        nb = k + DIM - 1;
        if (fill)
            for (int r = 0; r < KMAX; r++)
                for (int c = 0; c < DIM; c++) begin
                    a_mat[r][c] = W'($urandom);
                    b_mat[r][c] = W'($urandom);
                end
        cmd_valid_i    = 1'b1;
        cmd_k_i        = KW'(k_cmd);
        halt_i         = 1'b0;
        edge_a_ready_i = '1;
        edge_b_ready_i = '1;
        a_vec_valid_i  = 1'b1;
        b_vec_valid_i  = 1'b1;
        a_vec_i        = pack_vec(1'b0, 0);
        b_vec_i        = pack_vec(1'b1, 0);
        @(negedge clk);
        check("accept_ready", 64'(cmd_ready_o), 64'(1));
        check("accept_busy", 64'(busy_o), 64'(0));
        check("accept_no_beat", 64'({edge_a_valid_o, edge_b_valid_o, a_vec_ready_o}), 64'(0));
        @(posedge clk); #1;
        if (!hold_cmd) cmd_valid_i = 1'b0;
        n = 0; phase = 0; settle_left = SET; cyc = 0; hcnt = 0; fin = 1'b0;
        while (!fin && cyc < 400) begin
            halt_i = rnd ? ($urandom_range(9) == 0) : 1'b0;
            if (halt_flush && phase == 2 && hcnt < 3) begin
                halt_i = 1'b1;
                hcnt++;
            end
            for (int i = 0; i < DIM; i++) begin
                edge_a_ready_i[i] = rnd ? ($urandom_range(7) != 0) : 1'b1;
                edge_b_ready_i[i] = rnd ? ($urandom_range(7) != 0) : 1'b1;
            end
            if (stall_b1 && cyc >= 1 && cyc < 6) edge_b_ready_i[1] = 1'b0;
            a_vec_valid_i = rnd ? ($urandom_range(4) != 0) : 1'b1;
            b_vec_valid_i = rnd ? ($urandom_range(4) != 0) : 1'b1;
            if (n < k) begin
                a_vec_i = pack_vec(1'b0, n);
                b_vec_i = pack_vec(1'b1, n);
            end else begin
                for (int i = 0; i < DIM; i++) begin
                    a_vec_i[i*W +: W] = W'($urandom);
                    b_vec_i[i*W +: W] = W'($urandom);
                end
            end
            @(negedge clk);
            ok       = (&edge_a_ready_i) && (&edge_b_ready_i) && !halt_i;
            exp_beat = (phase == 0) && ok && (n >= k || (a_vec_valid_i && b_vec_valid_i));
            check("edge_a_valid", 64'(edge_a_valid_o), 64'({DIM{exp_beat}}));
            check("edge_b_valid", 64'(edge_b_valid_o), 64'({DIM{exp_beat}}));
            check("a_vec_ready", 64'(a_vec_ready_o), 64'(exp_beat && n < k));
            check("b_vec_ready", 64'(b_vec_ready_o), 64'(exp_beat && n < k));
            check("en", 64'(en_o), 64'(!halt_i));
            check("busy", 64'(busy_o), 64'(1));
            check("cmd_ready_busy", 64'(cmd_ready_o), 64'(0));
            check("flush", 64'(flush_o), 64'(phase == 2 && !halt_i));
            check("done", 64'(done_o), 64'(phase == 3 && !halt_i));
            if (exp_beat) begin
                check("edge_a_data", 64'(edge_a_o), 64'(exp_edge(1'b0, n, k)));
                check("edge_b_data", 64'(edge_b_o), 64'(exp_edge(1'b1, n, k)));
                $display("job k=%0d beat %0d a=%h b=%h", k, n, edge_a_o, edge_b_o);
                n++;
                if (n == nb) phase = 1;
            end else if (phase == 1 && !halt_i) begin
                settle_left--;
                if (settle_left == 0) phase = 2;
            end else if (phase == 2 && !halt_i) begin
                phase = 3;
            end else if (phase == 3 && !halt_i) begin
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!fin) check("job_timeout", 64'(0), 64'(1));
        $display("job k_cmd=%0d k=%0d done after %0d cycles", k_cmd, k, cyc);
    endtask

    task automatic reset_mid_drain();
        for (int r = 0; r < KMAX; r++)
            for (int c = 0; c < DIM; c++) begin
                a_mat[r][c] = W'($urandom_range(1, 65535));
                b_mat[r][c] = W'($urandom_range(1, 65535));
            end
        cmd_valid_i = 1'b1; cmd_k_i = KW'(2); halt_i = 1'b0;
        edge_a_ready_i = '1; edge_b_ready_i = '1;
        a_vec_valid_i = 1'b1; b_vec_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            a_vec_i = pack_vec(1'b0, b);
            b_vec_i = pack_vec(1'b1, b);
            @(posedge clk); #1;
        end
        check("drain_busy", 64'(busy_o), 64'(1));
        check("drain_skew_nonzero", 64'(edge_a_o[W +: W] != '0), 64'(1));
        reset_n_i = 1'b0;
        #1;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
        check("rst_edge_valid", 64'({edge_a_valid_o, edge_b_valid_o}), 64'(0));
        check("rst_edge_data", 64'({edge_a_o, edge_b_o}), 64'(0));
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        for (int c = 0; c < SET + 6; c++) begin
            @(negedge clk);
            check("rst_no_flush_done", 64'({flush_o, done_o}), 64'(0));
            @(posedge clk); #1;
        end
        $display("reset mid-drain: aborted job");
    endtask

    initial begin
        reset_n_i = 1'b0; halt_i = 1'b1; cmd_valid_i = 1'b0; cmd_k_i = '0;
        a_vec_valid_i = 1'b0; b_vec_valid_i = 1'b0; a_vec_i = '0; b_vec_i = '0;
        edge_a_ready_i = '1; edge_b_ready_i = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_en_halted", 64'(en_o), 64'(0));
        halt_i = 1'b0;
        #1;
        check("reset_cmd_ready", 64'(cmd_ready_o), 64'(1));
        check("reset_en", 64'(en_o), 64'(1));
        check("reset_outs", 64'({busy_o, flush_o, done_o, a_vec_ready_o, b_vec_ready_o,
                                 edge_a_valid_o, edge_b_valid_o}), 64'(0));
        check("reset_edge_data", 64'({edge_a_o, edge_b_o}), 64'(0));
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        @(posedge clk); #1;

        a_mat[0][0] = 16'd1; a_mat[0][1] = 16'd2; a_mat[1][0] = 16'd3; a_mat[1][1] = 16'd4;
        b_mat[0][0] = 16'd5; b_mat[0][1] = 16'd6; b_mat[1][0] = 16'd7; b_mat[1][1] = 16'd8;
        run_job(2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(5, 1'b1, 1'b0, 1'b1, 1'b0);
        run_job(3, 1'b1, 1'b0, 1'b0, 1'b1);
        reset_mid_drain();
        hold_cmd = 1'b1;
        run_job(2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(4, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_cmd = 1'b0;
        cmd_valid_i = 1'b0;
        run_job(7, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++)
            run_job($urandom_range(0, 7), 1'b1, 1'b1, 1'b0, j % 4 == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
